var_delay_line: RTL and testbench
=================================

VAR_DELAY_LINE -- requirements
Module: var_delay_line

Interface
REQ-001 Parameter WIDTH, default 8, data bits per stage (>=1).
REQ-002 Parameter MAX_DEPTH, default 16, number of stages (>=2).
REQ-003 Parameter DEFAULT_DELAY, default 1, active delay after reset (1..MAX_DEPTH).
REQ-004 Derived DW = $clog2(MAX_DEPTH+1), width of delay ports.
REQ-005 The block SHALL have one clock and a synchronous, active-low reset.
REQ-006 clk_in  input  1  sole clock, all state on rising edge.
REQ-007 rst_in  input  1  synchronous active-low reset.
REQ-008 ce_in  input  1  clock enable; 0 = line and settle counter hold.
REQ-009 flush_in  input  1  clears all stages (valid and data).
REQ-010 delay_in  input  DW  requested delay in ce cycles.
REQ-011 data_in  input  WIDTH  sample entering stage 0.
REQ-012 valid_in  input  1  qualifier for data_in.
REQ-013 data_out  output  WIDTH  sample at active tap, masked.
REQ-014 valid_out  output  1  qualifier at active tap, masked.
REQ-015 settling_out  output  1  high while in SETTLE state.
REQ-016 delay_out  output  DW  currently active (clamped) delay.

Function
REQ-017 Each stage SHALL hold {valid, data}; on a ce_in=1 cycle stage[0] <= {valid_in, data_in} and stage[k] <= stage[k-1].
REQ-018 When ce_in=0, all stages, the active delay and the settle counter SHALL hold.
REQ-019 delay_in SHALL be clamped every cycle: 0 -> 1, >MAX_DEPTH -> MAX_DEPTH.
REQ-020 In RUN, data_out/valid_out SHALL be the combinational tap stage[D-1], where D = delay_out; a sample entering at ce edge n appears at the output after ce edge n+D-1, i.e. D ce-cycles of latency.
REQ-021 FSM states RUN and SETTLE; reset state RUN.
REQ-022 RUN -> SETTLE when the clamped delay_in differs from delay_out: delay_out <= clamped value and settle counter <= clamped value, at the same edge, regardless of ce_in.
REQ-023 In SETTLE the counter SHALL decrement on each ce_in=1 cycle; SETTLE -> RUN at the edge where it decrements from 1 to 0.
REQ-024 A further delay change during SETTLE SHALL reload delay_out and the counter and stay in SETTLE.
REQ-025 In SETTLE, valid_out and data_out SHALL be forced to 0; settling_out = 1.
REQ-026 flush_in=1 SHALL clear every stage to 0 at that edge, overriding ce_in and valid_in; FSM state and counter are unaffected.
REQ-027 In RUN with unchanged delay, valid_out SHALL never rise without a matching valid_in D ce-cycles earlier (no duplicates, no drops).

Reset
REQ-028 On rst_in=0 at a rising edge: all stages 0, state RUN, counter 0, delay_out = DEFAULT_DELAY.
REQ-029 Output values under reset: data_out=0, valid_out=0, settling_out=0, delay_out=DEFAULT_DELAY.
REQ-030 Reset SHALL override flush_in, ce_in and delay changes; reset mid-SETTLE returns to RUN.

Structure
REQ-031 Package delay_line_pkg SHALL hold the RUN/SETTLE state enum and the clamp function.
REQ-032 Stage array, FSM, counter and output mux SHALL be inline; no sub-module.
REQ-033 Elaboration SHALL fail if MAX_DEPTH<2 or DEFAULT_DELAY outside 1..MAX_DEPTH.

Verification
REQ-034 WIDTH=8, MAX_DEPTH=16, delay_in=4, ce=1, valid pulse data 0xA5 at edge 10 -> valid_out=1, data_out=0xA5 after edge 13 only.
REQ-035 delay_in 4->9 during a stream of incrementing bytes -> settling_out=1 for 9 ce-cycles, outputs 0, then stream resumes with 9-cycle latency and no repeated values.
REQ-036 ce_in low for 5 cycles mid-stream at delay 3 -> outputs frozen 5 cycles, sequence intact afterwards; settle counter frozen if in SETTLE.
REQ-037 flush_in one cycle with 4 items in flight at delay 8 -> those items never appear; item entering the cycle after flush appears 8 cycles later.
REQ-038 delay_in=0 and delay_in=20 -> delay_out reads 1 and 16 respectively.
REQ-039 rst_in low mid-SETTLE with items in flight -> next cycle state RUN, delay_out=1, valid_out=0; no stale items emerge.

Source files
------------

// File: rtl/delay_line_pkg.sv
// Shared types and helpers for the variable-length delay line.
package delay_line_pkg;

    // Two-state controller: normal tapping, or masking outputs while a new
    // tap position fills with samples that really are D ce-cycles old.
    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_SETTLE = 1'b1
    } state_e;

    // Map a requested delay onto the legal range 1..max_depth.
    // A request of 0 is treated as the shortest delay (one stage).
    function automatic int unsigned clamp_delay(
        input int unsigned req,
        input int unsigned max_depth
    );
        int unsigned res;
        if (req == 32'd0) begin
            res = 32'd1;
        end else if (req > max_depth) begin
            res = max_depth;
        end else begin
            res = req;
        end
        return res;
    endfunction

endpackage

// File: rtl/var_delay_line.sv
// Variable-length delay line with a run/settle controller.
// Samples ({valid, data}) shift through MAX_DEPTH stages on every ce cycle;
// the output taps stage[D-1]. When D changes, outputs are masked for D ce
// cycles so that nothing from the old tap alignment leaks out.
module var_delay_line
    import delay_line_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int MAX_DEPTH     = 16,
    parameter int DEFAULT_DELAY = 1,
    localparam int DW           = $clog2(MAX_DEPTH + 1)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             ce_in,
    input  logic             flush_in,
    input  logic [DW-1:0]    delay_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             settling_out,
    output logic [DW-1:0]    delay_out
);

    // Reject parameter sets the datapath cannot represent.
    if (MAX_DEPTH < 2) begin : g_bad_depth
        $error("var_delay_line: MAX_DEPTH must be at least 2");
    end
    if ((DEFAULT_DELAY < 1) || (DEFAULT_DELAY > MAX_DEPTH)) begin : g_bad_default
        $error("var_delay_line: DEFAULT_DELAY must lie in 1..MAX_DEPTH");
    end

    localparam int SW = WIDTH + 1;  // one stage: {valid, data}

    logic [MAX_DEPTH-1:0][SW-1:0] r_stage;
    state_e                       r_state;
    logic [DW-1:0]                r_delay;
    logic [DW-1:0]                r_settle_cnt;

    logic [DW-1:0]                w_delay_clamped;
    logic                         w_delay_change;
    logic [DW-1:0]                w_tap_idx;
    logic [SW-1:0]                w_tap;

    assign w_delay_clamped = DW'(clamp_delay(32'(delay_in), 32'(MAX_DEPTH)));
    assign w_delay_change  = (w_delay_clamped != r_delay);
    // r_delay is never 0, so the subtraction cannot wrap.
    assign w_tap_idx       = r_delay - DW'(1);

    // Stage shift register: flush beats ce, ce=0 holds everything.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_stage <= {(MAX_DEPTH * SW){1'b0}};
        end else if (flush_in) begin
            r_stage <= {(MAX_DEPTH * SW){1'b0}};
        end else if (ce_in) begin
            r_stage <= {r_stage[MAX_DEPTH-2:0], {valid_in, data_in}};
        end else begin
            r_stage <= r_stage;
        end
    end

    // Run/settle controller: a delay change is taken immediately (even with
    // ce low); the settle count only advances on ce cycles.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state      <= ST_RUN;
            r_delay      <= DW'(DEFAULT_DELAY);
            r_settle_cnt <= {DW{1'b0}};
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_delay_change) begin
                        r_state      <= ST_SETTLE;
                        r_delay      <= w_delay_clamped;
                        r_settle_cnt <= w_delay_clamped;
                    end else begin
                        r_state      <= ST_RUN;
                        r_delay      <= r_delay;
                        r_settle_cnt <= r_settle_cnt;
                    end
                end
                ST_SETTLE: begin
                    if (w_delay_change) begin
                        r_state      <= ST_SETTLE;
                        r_delay      <= w_delay_clamped;
                        r_settle_cnt <= w_delay_clamped;
                    end else if (ce_in) begin
                        r_delay      <= r_delay;
                        r_settle_cnt <= r_settle_cnt - DW'(1);
                        if (r_settle_cnt == DW'(1)) begin
                            r_state <= ST_RUN;
                        end else begin
                            r_state <= ST_SETTLE;
                        end
                    end else begin
                        r_state      <= ST_SETTLE;
                        r_delay      <= r_delay;
                        r_settle_cnt <= r_settle_cnt;
                    end
                end
                default: begin
                    r_state      <= ST_RUN;
                    r_delay      <= r_delay;
                    r_settle_cnt <= {DW{1'b0}};
                end
            endcase
        end
    end

    // Tap select: one-hot AND/OR mux over the stages, avoids an index wider
    // than the stage array.
    always_comb begin
        w_tap = {SW{1'b0}};
        for (int k = 0; k < MAX_DEPTH; k++) begin
            w_tap = w_tap | (r_stage[k] & {SW{(w_tap_idx == DW'(k))}});
        end
    end

    // Output mask: nothing leaves the line while the new tap is filling.
    always_comb begin
        if (r_state == ST_SETTLE) begin
            data_out  = {WIDTH{1'b0}};
            valid_out = 1'b0;
        end else begin
            data_out  = w_tap[WIDTH-1:0];
            valid_out = w_tap[WIDTH];
        end
    end

    assign settling_out = (r_state == ST_SETTLE);
    assign delay_out    = r_delay;

endmodule

// File: tb/tb_var_delay_line.sv
// Directed, scoreboard-checked bench for var_delay_line.
module tb_var_delay_line;

    localparam int WIDTH = 8;
    localparam int MAXD  = 16;
    localparam int DW    = $clog2(MAXD + 1);

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             ce_in;
    logic             flush_in;
    logic [DW-1:0]    delay_in;
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             settling_out;
    logic [DW-1:0]    delay_out;

    var_delay_line #(
        .WIDTH(WIDTH), .MAX_DEPTH(MAXD), .DEFAULT_DELAY(1)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .ce_in(ce_in), .flush_in(flush_in),
        .delay_in(delay_in), .data_in(data_in), .valid_in(valid_in),
        .data_out(data_out), .valid_out(valid_out),
        .settling_out(settling_out), .delay_out(delay_out)
    );

    always #5 clk_in = ~clk_in;

    // Scoreboard: every sample captured on a ce edge, tagged with that edge's index.
    typedef struct {
        logic             v;
        logic [WIDTH-1:0] d;
        int               idx;
    } ent_t;
    ent_t q[$];

    int checks = 0;
    int failures = 0;
    int ce_count = 0;
    int m_delay = 1;
    int m_cnt = 0;
    bit m_settle = 1'b0;
    logic             exp_v;
    logic [WIDTH-1:0] exp_d;
    int win_valid = 0;
    int win_settle = 0;
    logic [WIDTH-1:0] seq = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int clampv(input int r);
        if (r < 1) return 1;
        if (r > MAXD) return MAXD;
        return r;
    endfunction

    // Apply the inputs seen at this edge to the reference and derive outputs.
    task automatic model_edge();
        int target;
        int cl;
        if (!rst_in) begin
            q.delete();
            m_settle = 1'b0;
            m_cnt    = 0;
            m_delay  = 1;
        end else begin
            if (ce_in) ce_count++;
            if (flush_in) q.delete();
            else if (ce_in) q.push_back('{valid_in, data_in, ce_count});
            cl = clampv(int'(delay_in));
            if (cl != m_delay) begin
                m_delay  = cl;
                m_cnt    = cl;
                m_settle = 1'b1;
            end else if (m_settle && ce_in) begin
                m_cnt--;
                if (m_cnt == 0) m_settle = 1'b0;
            end
        end
        target = ce_count - m_delay + 1;
        while (q.size() > 0 && q[0].idx < target) void'(q.pop_front());
        exp_v = 1'b0;
        exp_d = 8'h00;
        if (!m_settle && q.size() > 0 && q[0].idx == target) begin
            exp_v = q[0].v;
            exp_d = q[0].d;
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        model_edge();
        #1;
        chk("valid_out",    32'(valid_out),    32'(exp_v));
        chk("data_out",     32'(data_out),     32'(exp_d));
        chk("settling_out", 32'(settling_out), 32'(m_settle));
        chk("delay_out",    32'(delay_out),    32'(m_delay));
        win_valid  += int'(valid_out);
        win_settle += int'(settling_out);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            valid_in = 1'b0; data_in = 8'h00; ce_in = 1'b1;
            cyc();
        end
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            valid_in = 1'b1; data_in = seq; ce_in = 1'b1;
            seq = seq + 8'h01;
            cyc();
        end
    endtask

    initial begin
        rst_in = 1'b0; ce_in = 1'b0; flush_in = 1'b0;
        delay_in = 5'd1; data_in = 8'h00; valid_in = 1'b0;
        cyc();
        cyc();
        chk("reset_delay_const", 32'(delay_out), 32'd1);
        rst_in = 1'b1;
        idle(3);

        // Single pulse at delay 4: appears exactly once, D-1 edges after capture.
        delay_in = 5'd4;
        idle(5);
        win_valid = 0;
        valid_in = 1'b1; data_in = 8'hA5; ce_in = 1'b1;
        cyc();
        idle(2);
        chk("pulse_early", 32'(valid_out), 32'd0);
        idle(1);
        chk("pulse_valid", 32'(valid_out), 32'd1);
        chk("pulse_data",  32'(data_out),  32'hA5);
        idle(5);
        chk("pulse_once", 32'(win_valid), 32'd1);

        // Delay 4 -> 9 in the middle of an incrementing stream.
        stream(10);
        win_settle = 0;
        delay_in = 5'd9;
        stream(25);
        chk("settle_len_9", 32'(win_settle), 32'd9);

        // Delay 3 stream with a 5-cycle ce hold, then ce hold inside SETTLE.
        delay_in = 5'd3;
        stream(12);
        for (int i = 0; i < 5; i++) begin
            ce_in = 1'b0; valid_in = 1'b1; data_in = 8'hEE;
            cyc();
        end
        stream(6);
        win_settle = 0;
        delay_in = 5'd5;
        stream(1);
        for (int i = 0; i < 3; i++) begin
            ce_in = 1'b0; valid_in = 1'b0; data_in = 8'h00;
            cyc();
        end
        stream(10);
        chk("settle_len_frozen", 32'(win_settle), 32'd8);

        // Flush at delay 8 with four items in flight.
        delay_in = 5'd8;
        idle(10);
        stream(4);
        win_valid = 0;
        flush_in = 1'b1; valid_in = 1'b1; data_in = 8'h77; ce_in = 1'b1;
        cyc();
        flush_in = 1'b0;
        valid_in = 1'b1; data_in = 8'h99;
        cyc();
        idle(6);
        chk("flush_item_early", 32'(valid_out), 32'd0);
        idle(1);
        chk("flush_item_valid", 32'(valid_out), 32'd1);
        chk("flush_item_data",  32'(data_out),  32'h99);
        idle(3);
        chk("flush_only_one", 32'(win_valid), 32'd1);

        // Clamp boundaries.
        delay_in = 5'd0;
        idle(1);
        chk("clamp_low",  32'(delay_out), 32'd1);
        idle(2);
        delay_in = 5'd20;
        idle(1);
        chk("clamp_high", 32'(delay_out), 32'd16);

        // Reset mid-SETTLE with items in flight.
        delay_in = 5'd12;
        stream(6);
        rst_in = 1'b0; flush_in = 1'b0;
        stream(1);
        rst_in = 1'b1;
        chk("rst_settling", 32'(settling_out), 32'd0);
        chk("rst_delay",    32'(delay_out),    32'd1);
        chk("rst_valid",    32'(valid_out),    32'd0);
        delay_in = 5'd1;
        win_valid = 0;
        idle(20);
        chk("rst_no_stale", 32'(win_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
